// File: rtl/useq_fetch_pkg.sv
// useq_pkg: opcodes, FSM states and 20-bit word field positions shared by the useq_fetch sequencer.
package useq_pkg;
    localparam logic [3:0] OP_EXEC = 4'h0;
    localparam logic [3:0] OP_JUMP = 4'h2;
    localparam logic [3:0] OP_WAIT = 4'h4;
    localparam logic [3:0] OP_CALL = 4'h8;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EMIT, WAIT} state_t;
    localparam int OP_LSB  = 12;
    localparam int SEL_LSB = 8;
    localparam int IMM_LSB = 0;
endpackage

// File: rtl/useq_fetch_if.sv
// useq_fetch_if: ROM address/data bus plus the execute micro-op valid/ready handshake.
interface useq_fetch_if #(
    parameter int AW = 6,
    parameter int DW = 20
);
    logic [AW-1:0] addr;
    logic [DW-1:0] rom_dout;
    logic          ins_valid;
    logic          ins_ready;
    logic [11:0]   ins_data;
    modport master (output addr, ins_valid, ins_data, input rom_dout, ins_ready);
    modport slave  (input addr, ins_valid, ins_data, output rom_dout, ins_ready);
endinterface

// File: rtl/useq_fetch_stack.sv
// useq_stack: return-address LIFO; dout always shows the top entry, push/pop are ignored when full/empty.
module useq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] sp;
    logic [IW-1:0] top;
    assign top   = IW'(sp - 1'b1);
    assign full  = sp == PW'(DEPTH);
    assign empty = sp == '0;
    assign dout  = mem[top];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp <= '0;
        else
            sp <= sp + PW'(push && !full) - PW'(pop && !empty);
    end
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[IW'(sp)] <= din;
    end
endmodule

// File: rtl/useq_fetch.sv
// useq_fetch: microprogram sequencer driving a 1-cycle-latency ROM and emitting execute micro-ops.
// Defining USEQ_PERF_CNT_EN adds the perf_cnt port counting accepted micro-ops.
module useq_fetch
    import useq_pkg::*;
#(
    parameter int AW          = 6,
    parameter int DW          = 20,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   cond,
    useq_fetch_if.master bus,
`ifdef USEQ_PERF_CNT_EN
    output logic [15:0]  perf_cnt,
`endif
    output logic         busy,
    output logic         err
);
    state_t        state;
    logic [AW-1:0] pc, pc_inc, tgt, stk_dout;
    logic [3:0]    op, sel;
    logic [7:0]    imm, wcnt;
    logic          push, pop, full, empty, taken;
    logic          unused_bits;

    assign op          = bus.rom_dout[OP_LSB +: 4];
    assign sel         = bus.rom_dout[SEL_LSB +: 4];
    assign imm         = bus.rom_dout[IMM_LSB +: 8];
    assign unused_bits = &{1'b0, bus.rom_dout[DW-1:16]};
    assign tgt         = imm[AW-1:0];
    assign pc_inc      = pc + 1'b1;
    assign taken       = sel == 4'd0 || cond[sel[1:0]];
    assign push        = state == DECODE && op == OP_CALL && !full;
    assign pop         = state == DECODE && op == OP_RET && !empty;
    assign busy        = state != IDLE;
    assign bus.addr    = pc;

    useq_stack #(.DEPTH(STACK_DEPTH), .W(AW)) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= '0;
            wcnt          <= '0;
            err           <= 1'b0;
            bus.ins_valid <= 1'b0;
            bus.ins_data  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pc    <= AW'(START_ADDR);
                    err   <= 1'b0;
                    state <= FETCH;
                end
                FETCH: state <= DECODE;
                DECODE: case (op)
                    OP_JUMP: begin
                        pc    <= taken ? tgt : pc_inc;
                        state <= FETCH;
                    end
                    OP_WAIT: begin
                        pc    <= imm == 8'd0 ? pc_inc : pc;
                        wcnt  <= imm;
                        state <= imm == 8'd0 ? FETCH : WAIT;
                    end
                    OP_CALL: begin
                        err   <= err | full;
                        pc    <= full ? pc : tgt;
                        state <= full ? IDLE : FETCH;
                    end
                    OP_RET: begin
                        err   <= err | empty;
                        pc    <= empty ? pc : stk_dout;
                        state <= empty ? IDLE : FETCH;
                    end
                    OP_HALT: state <= IDLE;
                    default: begin
                        bus.ins_data  <= {sel, imm};
                        bus.ins_valid <= 1'b1;
                        state         <= EMIT;
                    end
                endcase
                EMIT: if (bus.ins_ready) begin
                    bus.ins_valid <= 1'b0;
                    pc            <= pc_inc;
                    state         <= FETCH;
                end
                WAIT: begin
                    wcnt <= wcnt - 1'b1;
                    if (wcnt == 8'd1) begin
                        pc    <= pc_inc;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef USEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_cnt <= '0;
        else if (state == IDLE && start)
            perf_cnt <= '0;
        else if (state == EMIT && bus.ins_ready)
            perf_cnt <= perf_cnt + 1'b1;
    end
`endif
endmodule
